turbo_scheduler: RTL and testbench

TURBO_SCHEDULER -- requirements
Module: turbo_scheduler

---
 rtl/turbo_pkg.sv | 37 +++
 rtl/turbo_step.sv | 39 +++
 rtl/turbo_scheduler.sv | 112 +++++++++++
 tb/tb_turbo_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/turbo_pkg.sv
`default_nettype none
// ============================================================================
// turbo_pkg : shared constants, FSM state type and speed->threshold mapping
// Revision  : 1.0
// ============================================================================
package turbo_pkg;

  localparam int NUM_CH      = 8;
  localparam int NUM_PLAYERS = 4;
  localparam int CNT_W       = 4;
  localparam int SPEED_W     = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic logic speed_disabled(input logic [SPEED_W-1:0] speed);
    return (speed == 3'd0) || (speed == 3'd7);
  endfunction

  // Count limit per speed; larger limit means slower toggling.
  function automatic logic [CNT_W-1:0] speed_threshold(input logic [SPEED_W-1:0] speed);
    logic [CNT_W-1:0] thr;
    case (speed)
      3'd1:    thr = 4'd9;
      3'd2:    thr = 4'd5;
      3'd3:    thr = 4'd3;
      3'd4:    thr = 4'd2;
      3'd5:    thr = 4'd1;
      default: thr = 4'd0;
    endcase
    return thr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/turbo_step.sv
`default_nettype none
// ============================================================================
// turbo_step : combinational next-state for one turbo channel
// Revision   : 1.0
// ============================================================================
module turbo_step
  import turbo_pkg::*;
(
  input  logic [CNT_W-1:0]   cnt,
  input  logic               turbo,
  input  logic               button,
  input  logic [SPEED_W-1:0] speed,
  output logic [CNT_W-1:0]   cnt_next,
  output logic               turbo_next
);

  logic [CNT_W-1:0] w_thresh;

  assign w_thresh = speed_threshold(speed);

  // A released button keeps the channel running until its output returns low.
  always_comb begin
    cnt_next   = cnt;
    turbo_next = turbo;
    if (button || turbo) begin
      if (speed_disabled(speed)) begin
        cnt_next   = '0;
        turbo_next = 1'b0;
      end else if (cnt >= w_thresh) begin
        cnt_next   = '0;
        turbo_next = ~turbo;
      end else begin
        cnt_next = cnt + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/turbo_scheduler.sv
`default_nettype none
// ============================================================================
// turbo_scheduler : per-frame turbo toggling, one shared datapath over 8 channels
// Revision        : 1.0
// ============================================================================
module turbo_scheduler
  import turbo_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         vsync,
  input  logic [SPEED_W*NUM_PLAYERS-1:0] turbo_speed,
  input  logic [NUM_CH-1:0]            button_turbo,
  output logic [NUM_CH-1:0]            turbo,
  output logic                         busy,
  output logic                         overrun
);

  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic               pending_q, pending_d;
  logic               overrun_q, overrun_d;
  logic               prev_vsync_q;
  logic               armed_q;
  logic [CNT_W-1:0]   cnt_q [NUM_CH];
  logic [NUM_CH-1:0]  turbo_q;

  logic [SPEED_W-1:0] w_speed [NUM_PLAYERS];
  logic               w_tick;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_turbo_next;

  generate
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
      assign w_speed[p] = turbo_speed[SPEED_W*p +: SPEED_W];
    end
  endgenerate

  // armed_q forces a fresh 0->1 edge after reset, so a held-high vsync is ignored.
  assign w_tick = vsync & ~prev_vsync_q & armed_q;

  turbo_step u_step (
    .cnt        (cnt_q[idx_q]),
    .turbo      (turbo_q[idx_q]),
    .button     (button_turbo[idx_q]),
    .speed      (w_speed[idx_q[2:1]]),
    .cnt_next   (w_cnt_next),
    .turbo_next (w_turbo_next)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_tick) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (w_tick) begin
          if (pending_q) overrun_d = 1'b1;
          else           pending_d = 1'b1;
        end
        idx_d = idx_q + 3'd1;
        // Last channel: a queued frame (even one arriving now) restarts at once.
        if (idx_q == 3'(NUM_CH-1)) begin
          if (pending_d) pending_d = 1'b0;
          else           state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      prev_vsync_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      prev_vsync_q <= vsync;
      armed_q      <= armed_q | ~vsync;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      turbo_q <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else if (state_q == SCAN) begin
      cnt_q[idx_q]   <= w_cnt_next;
      turbo_q[idx_q] <= w_turbo_next;
    end
  end

  assign turbo   = turbo_q;
  assign busy    = (state_q == SCAN);
  assign overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_turbo_scheduler.sv
`default_nettype none
// ============================================================================
// tb_turbo_scheduler : directed scenarios plus random traffic vs. frame-level model
// Revision           : 1.0
// ============================================================================
module tb_turbo_scheduler;

  logic        clk;
  logic        reset_n;
  logic        vsync;
  logic [11:0] turbo_speed;
  logic [7:0]  button_turbo;
  logic [7:0]  turbo;
  logic        busy;
  logic        overrun;

  turbo_scheduler dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .vsync        (vsync),
    .turbo_speed  (turbo_speed),
    .button_turbo (button_turbo),
    .turbo        (turbo),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else             n_pass++;
  endtask

  // Reference model: scan position -1 means idle, else the channel handled next.
  int       thr [8] = '{0, 9, 5, 3, 2, 1, 0, 0};
  int       m_cnt [8];
  bit [7:0] m_turbo;
  int       m_pos;
  bit       m_pend, m_prev, m_armed, m_ovr;

  task automatic model_step(input bit vs, input bit [11:0] spd, input bit [7:0] btn, input bit rn);
    bit tick;
    int ch, sp;
    if (!rn) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      m_turbo = '0; m_pos = -1; m_pend = 0; m_prev = 0; m_armed = 0; m_ovr = 0;
      return;
    end
    tick  = vs && !m_prev && m_armed;
    m_ovr = 0;
    if (m_pos >= 0) begin
      ch = m_pos;
      sp = (spd >> (3 * (ch / 2))) & 7;
      if (!btn[ch] && !m_turbo[ch]) begin
      end else if (sp == 0 || sp == 7) begin
        m_cnt[ch] = 0; m_turbo[ch] = 0;
      end else if (m_cnt[ch] >= thr[sp]) begin
        m_cnt[ch] = 0; m_turbo[ch] = !m_turbo[ch];
      end else begin
        m_cnt[ch] = m_cnt[ch] + 1;
      end
      if (tick) begin
        if (m_pend) m_ovr = 1;
        else        m_pend = 1;
      end
      if (m_pos == 7) begin
        if (m_pend) begin m_pend = 0; m_pos = 0; end
        else        m_pos = -1;
      end else begin
        m_pos++;
      end
    end else if (tick) begin
      m_pos = 0;
    end
    m_armed = m_armed || !vs;
    m_prev  = vs;
  endtask

  task automatic step(input bit vs, input bit [11:0] spd, input bit [7:0] btn, input bit rn);
    vsync = vs; turbo_speed = spd; button_turbo = btn; reset_n = rn;
    @(posedge clk);
    model_step(vs, spd, btn, rn);
    #1;
    chk("turbo", 32'(turbo), 32'(m_turbo));
    chk("busy", 32'(busy), 32'(m_pos >= 0));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    for (int i = 0; i < 8; i++) chk($sformatf("cnt%0d", i), 32'(dut.cnt_q[i]), 32'(m_cnt[i]));
  endtask

  task automatic frame(input bit [11:0] spd, input bit [7:0] btn);
    step(1, spd, btn, 1);
    repeat (9) step(0, spd, btn, 1);
  endtask

  task automatic do_reset();
    step(0, 12'h0, 8'h0, 0);
    step(0, 12'h0, 8'h0, 0);
    step(0, 12'h0, 8'h0, 1);
  endtask

  int busy_run;
  bit ended;
  bit [4:0] s4_vs;

  initial begin
    vsync = 0; turbo_speed = '0; button_turbo = '0; reset_n = 0;
    m_pos = -1;

    // Reset state
    do_reset();
    chk("rst_turbo", 32'(turbo), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);

    // All speed 6, all buttons: toggle every frame, channel i lands at k+1+i
    step(1, 12'hDB6, 8'hFF, 1);
    chk("s1_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 8; i++) begin
      step(0, 12'hDB6, 8'hFF, 1);
      chk($sformatf("s1_lat%0d", i), 32'(turbo), 32'((2 << i) - 1));
    end
    step(0, 12'hDB6, 8'hFF, 1);
    chk("s1_idle", 32'(busy), 32'h0);
    frame(12'hDB6, 8'hFF); chk("s1_f2", 32'(turbo), 32'h00);
    frame(12'hDB6, 8'hFF); chk("s1_f3", 32'(turbo), 32'hFF);
    frame(12'hDB6, 8'hFF); chk("s1_f4", 32'(turbo), 32'h00);

    // Player 0 speed 1, ch0 held: toggle every 10 ticks
    do_reset();
    for (int t = 1; t <= 20; t++) begin
      frame(12'h001, 8'h01);
      if (t == 9)  chk("s2_t9",  32'(turbo), 32'h00);
      if (t == 10) chk("s2_t10", 32'(turbo), 32'h01);
      if (t == 19) chk("s2_t19", 32'(turbo), 32'h01);
      if (t == 20) chk("s2_t20", 32'(turbo), 32'h00);
    end

    // Speed 2 on ch3, release after rise: falls 6 ticks later, then holds
    do_reset();
    repeat (5) frame(12'h010, 8'h08);
    chk("s3_pre", 32'(turbo), 32'h00);
    frame(12'h010, 8'h08);
    chk("s3_rise", 32'(turbo), 32'h08);
    repeat (5) frame(12'h010, 8'h00);
    chk("s3_hold1", 32'(turbo), 32'h08);
    frame(12'h010, 8'h00);
    chk("s3_fall", 32'(turbo), 32'h00);
    repeat (2) frame(12'h010, 8'h00);
    chk("s3_stay", 32'(turbo), 32'h00);
    chk("s3_cnt", 32'(dut.cnt_q[3]), 32'h0);

    // Two extra ticks in one scan: pending, then overrun; 16 busy cycles
    do_reset();
    busy_run = 0; ended = 0;
    s4_vs = 5'b10101;
    for (int j = 0; j < 30 && !ended; j++) begin
      step((j < 5) ? s4_vs[j] : 1'b0, 12'hDB6, 8'hFF, 1);
      if (j == 4) chk("s4_ovr", 32'(overrun), 32'h1);
      if (busy) busy_run++;
      else if (busy_run > 0) ended = 1;
    end
    chk("s4_busy_run", 32'(busy_run), 32'd16);

    // Player 2 speed 6->0 after idx 0 in the third frame
    do_reset();
    frame(12'hDB6, 8'hFF);
    frame(12'hDB6, 8'hFF);
    step(1, 12'hDB6, 8'hFF, 1);
    step(0, 12'hDB6, 8'hFF, 1);
    repeat (9) step(0, 12'hC36, 8'hFF, 1);
    chk("s5_turbo", 32'(turbo), 32'hCF);
    chk("s5_cnt4", 32'(dut.cnt_q[4]), 32'h0);
    chk("s5_cnt5", 32'(dut.cnt_q[5]), 32'h0);

    // Reset at idx 3 with turbo all high; held-high vsync gives no tick
    do_reset();
    frame(12'hDB6, 8'hFF);
    chk("s6_pre", 32'(turbo), 32'hFF);
    step(1, 12'h249, 8'hFF, 1);
    repeat (3) step(0, 12'h249, 8'hFF, 1);
    step(0, 12'h249, 8'hFF, 0);
    chk("s6_turbo", 32'(turbo), 32'h00);
    chk("s6_busy", 32'(busy), 32'h0);
    step(1, 12'h249, 8'hFF, 0);
    for (int j = 0; j < 4; j++) begin
      step(1, 12'h249, 8'hFF, 1);
      chk("s6_noTick", 32'(busy), 32'h0);
    end
    step(0, 12'h249, 8'hFF, 1);
    step(1, 12'h249, 8'hFF, 1);
    chk("s6_tick", 32'(busy), 32'h1);
    repeat (10) step(0, 12'h249, 8'hFF, 1);

    // Random traffic
    for (int j = 0; j < 3000; j++) begin
      step(($urandom_range(0, 4) == 0),
           12'($urandom),
           8'($urandom),
           ($urandom_range(0, 299) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
